// File: rtl/cordic_angle_feeder.sv
// cordic_angle_feeder
//   Front end of the iterative CORDIC sine/cosine core. Phase words arrive over a
//   valid/ready handshake, are folded to quadrant + first-quadrant angle (signed Q2.6 rad)
//   and buffered in a small FIFO. One angle is presented per CORDIC frame. The quadrant
//   of each real request is re-emitted through a delay line so that it lines up with the
//   core's registered sine/cosine result.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous reset, active low
//   phase_in_i     requested phase, unsigned, full circle = 2^PW
//   phase_valid_i  phase_in_i valid
//   phase_ready_o  FIFO can accept (transfer on valid & ready at the clock edge)
//   angle_o        core angle input, signed Q2.6 radians, range 0..101
//   frame_load_o   high during the cycle the core samples angle_o
//   slot_valid_o   angle_o carries a real request (0 = idle filler frame)
//   quad_out_o     quadrant of the result now at the core output
//   quad_valid_o   one-cycle pulse: core result belongs to a real request
//   fifo_count_o   current FIFO occupancy
module cordic_angle_feeder #(
    parameter int unsigned PW        = 10,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FRAME_LEN = 12,
    parameter int unsigned RES_LAT   = 13
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [PW-1:0]            phase_in_i,
    input  logic                     phase_valid_i,
    output logic                     phase_ready_o,
    output logic [7:0]               angle_o,
    output logic                     frame_load_o,
    output logic                     slot_valid_o,
    output logic [1:0]               quad_out_o,
    output logic                     quad_valid_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FRAME_LEN);

    // Frame counter
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          frame_load;
    logic          pop_edge;

    // FIFO
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic          nonempty;
    logic [9:0]    entry;
    logic [9:0]    head;

    // Fold
    logic [7:0]    off;
    logic [14:0]   prod;
    logic [6:0]    ang;

    // Slot and quadrant delay line
    logic [7:0]    angle_q, angle_d;
    logic          slot_valid_q, slot_valid_d;
    logic [1:0]    cur_quad_q, cur_quad_d;
    logic [2:0]    dly_q [RES_LAT];
    logic [2:0]    dly_d [RES_LAT];

    // ------------------------------------------------------------------
    // Combinational next state
    // ------------------------------------------------------------------
    assign frame_load = (fcnt_q == FW'(FRAME_LEN - 1));
    // The edge that moves fcnt into the frame_load cycle.
    assign pop_edge   = (fcnt_q == FW'(FRAME_LEN - 2));

    assign nonempty   = (count_q != '0);
    assign phase_ready_o = rst_ni && (count_q != CW'(DEPTH));
    assign push       = phase_valid_i && phase_ready_o;
    assign pop        = pop_edge && nonempty;
    assign head       = mem_q[rptr_q];

    // off * pi/8 in 1/64 rad, rounded; max 255*101+128 = 25883 fits 15 bits.
    assign off   = phase_in_i[PW-3 -: 8];
    assign prod  = 15'(off) * 15'd101 + 15'd128;
    assign ang   = 7'(prod >> 8);
    assign entry = {phase_in_i[PW-1:PW-2], 1'b0, ang};

    always_comb begin
        fcnt_d = frame_load ? '0 : fcnt_q + FW'(1);

        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        angle_d      = angle_q;
        slot_valid_d = slot_valid_q;
        cur_quad_d   = cur_quad_q;
        if (pop_edge) begin
            if (nonempty) begin
                angle_d      = head[7:0];
                slot_valid_d = 1'b1;
                cur_quad_d   = head[9:8];
            end else begin
                angle_d      = '0;
                slot_valid_d = 1'b0;
                cur_quad_d   = '0;
            end
        end
    end

    // Only frame_load cycles inject a token; all others shift in zeros so each
    // real request produces exactly one output pulse.
    always_comb begin
        dly_d[0] = frame_load ? {slot_valid_q, cur_quad_q} : 3'b000;
        for (int i = 1; i < RES_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fcnt_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            angle_q      <= '0;
            slot_valid_q <= 1'b0;
            cur_quad_q   <= '0;
            for (int i = 0; i < RES_LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            fcnt_q       <= fcnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            angle_q      <= angle_d;
            slot_valid_q <= slot_valid_d;
            cur_quad_q   <= cur_quad_d;
            for (int i = 0; i < RES_LAT; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign angle_o      = angle_q;
    assign frame_load_o = frame_load;
    assign slot_valid_o = slot_valid_q;
    assign quad_valid_o = dly_q[RES_LAT-1][2];
    assign quad_out_o   = dly_q[RES_LAT-1][1:0];
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_cordic_angle_feeder.sv
module tb_cordic_angle_feeder;

    localparam int PW    = 10;
    localparam int DEPTH = 4;
    localparam int FL    = 12;
    localparam int RL    = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] phase = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic [7:0]    angle;
    logic          frame_load;
    logic          slot_valid;
    logic [1:0]    quad_out;
    logic          quad_valid;
    logic [2:0]    fifo_count;

    cordic_angle_feeder #(
        .PW(PW), .DEPTH(DEPTH), .FRAME_LEN(FL), .RES_LAT(RL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .phase_in_i   (phase),
        .phase_valid_i(valid),
        .phase_ready_o(ready),
        .angle_o      (angle),
        .frame_load_o (frame_load),
        .slot_valid_o (slot_valid),
        .quad_out_o   (quad_out),
        .quad_valid_o (quad_valid),
        .fifo_count_o (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending phases, scheduled result pulses, current slot.
    int q_m[$];
    int due_c[$];
    int due_q[$];
    int t = 0;
    int exp_angle = 0;
    int exp_slot = 0;

    function automatic int fold(int p);
        int off;
        off = (p >> (PW - 10)) & 255;
        return (off * 101 + 128) / 256;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (t=%0d): observed %0d expected %0d", tag, t, obs, exp);
        end
    endtask

    task automatic check_all();
        bit exp_qv;
        chk("frame_load", frame_load, (t % FL == FL - 1));
        chk("angle", angle, exp_angle);
        chk("slot_valid", slot_valid, exp_slot);
        chk("phase_ready", ready, (q_m.size() < DEPTH));
        chk("fifo_count", fifo_count, q_m.size());
        exp_qv = (due_c.size() > 0) && (due_c[0] == t);
        chk("quad_valid", quad_valid, exp_qv);
        if (exp_qv) begin
            chk("quad_out", quad_out, due_q[0]);
            void'(due_c.pop_front());
            void'(due_q.pop_front());
        end
    endtask

    // Advance one clock with the currently driven inputs, update model, check.
    task automatic step(output bit acc);
        int fc;
        fc  = t % FL;
        acc = valid && (q_m.size() < DEPTH);
        @(posedge clk);
        if (fc == FL - 2) begin
            if (q_m.size() > 0) begin
                exp_angle = fold(q_m[0]);
                exp_slot  = 1;
                due_c.push_back(t + 1 + RL);
                due_q.push_back((q_m[0] >> (PW - 2)) & 3);
                void'(q_m.pop_front());
            end else begin
                exp_angle = 0;
                exp_slot  = 0;
            end
        end
        if (acc) q_m.push_back(int'(phase));
        t++;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    // Offer a list of phases back to back, holding valid until each is taken.
    task automatic offer(input int ph[$]);
        bit acc;
        int k;
        k = 0;
        while (k < ph.size()) begin
            valid = 1'b1;
            phase = PW'(ph[k]);
            step(acc);
            if (acc) k++;
        end
        valid = 1'b0;
    endtask

    // Assert reset now, check reset outputs, release on a falling edge.
    task automatic reset_now();
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        chk("rst_angle", angle, 0);
        chk("rst_slot_valid", slot_valid, 0);
        chk("rst_quad_valid", quad_valid, 0);
        chk("rst_quad_out", quad_out, 0);
        chk("rst_phase_ready", ready, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_frame_load", frame_load, 0);
        q_m.delete();
        due_c.delete();
        due_q.delete();
        exp_angle = 0;
        exp_slot  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        #1;
        check_all();
    endtask

    initial begin
        bit acc;
        int dens;
        int ph[$];

        // Idle frames after release.
        reset_now();
        idle(40);

        // Single request.
        offer('{'h040});
        idle(40);

        // Three back-to-back requests across quadrants 1..3.
        offer('{'h100, 'h2C0, 'h3FF});
        idle(60);

        // Burst of six against a 4-deep FIFO; align start just after a pop edge.
        while (t % FL != FL - 1) idle(1);
        offer('{'h011, 'h155, 'h2AA, 'h3E0, 'h0FF, 'h201});
        idle(90);

        // Full FIFO with valid held across the pop edge.
        offer('{'h080, 'h180, 'h280, 'h380});
        valid = 1'b1;
        phase = PW'('h0C0);
        while (!(q_m.size() == DEPTH && t % FL == FL - 2)) step(acc);
        step(acc);
        step(acc);
        valid = 1'b0;
        idle(80);

        // Reset with work queued and one in flight.
        offer('{'h050, 'h150, 'h250});
        while (!(t % FL == 5 && due_c.size() > 0 && q_m.size() == 2)) idle(1);
        reset_now();
        idle(50);

        // Randomized traffic with varying density.
        dens = 30;
        for (int i = 0; i < 700; i++) begin
            if (i % 100 == 0) dens = $urandom_range(5, 70);
            valid = ($urandom_range(0, 99) < dens);
            case ($urandom_range(0, 7))
                0:       phase = '0;
                1:       phase = '1;
                2:       phase = PW'($urandom_range(0, 3) << (PW - 2));
                default: phase = PW'($urandom_range(0, (1 << PW) - 1));
            endcase
            step(acc);
        end
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case a loop above stalls.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
